prog_data_mem: RTL and testbench
================================

Name: prog_data_mem

Overview:
- Memory-side responder for the 8-bit single-cycle CPU.
- Serves instruction fetch (PC -> Iin) and data load/store (DataA address, DataB write data, MW strobe -> Din).
- Contains a byte-serial program loader that fills instruction memory while the CPU is held in reset, then releases it.
- Sits between the top level / test host and the cpu instance.

Parameters:
- IMEM_WORDS, 128, number of 16-bit instruction words; must be ≤128, indexed by PC[7:1].
- DMEM_BYTES, 256, number of 8-bit data bytes, indexed by DataA.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- PC  input  8  CPU program counter (byte address, even).
- DataA  input  8  CPU data address.
- DataB  input  8  CPU store data.
- MW  input  1  CPU memory-write strobe.
- Iin  output  16  instruction to CPU.
- Din  output  8  load data to CPU.
- CPU_RST  output  1  drives CPU RESET; high while not running.
- LD_START  input  1  pulse: begin program load at word 0.
- LD_END  input  1  pulse: terminate program load.
- LD_VALID  input  1  loader byte valid.
- LD_BYTE  input  8  loader byte; high byte of each word first.
- LD_READY  output  1  loader may transfer a byte this cycle.
- LD_COUNT  output  8  words written in the current/last load.
- RUNNING  output  1  high in RUN state.

Behaviour:
- Clock/reset: one clock CLK; RESET is synchronous and active-high.
- Reset state:
  - state=HOLD, ptr=0, hi_reg=0, LD_COUNT=0.
  - CPU_RST=1, RUNNING=0, LD_READY=0.
  - Memory contents are not reset.
- States: HOLD, LOAD_HI, LOAD_LO, FLUSH, RUN.
- HOLD:
  - CPU_RST=1.
  - LD_START -> LOAD_HI, with ptr=0 and LD_COUNT=0.
- LOAD_HI:
  - LD_READY = ~LD_END.
  - Handshake (LD_VALID & LD_READY): hi_reg <= LD_BYTE -> LOAD_LO.
  - LD_END -> FLUSH; no write.
- LOAD_LO:
  - LD_READY = ~LD_END.
  - Handshake: imem[ptr] <= {hi_reg, LD_BYTE}; ptr++, LD_COUNT++.
  - After a handshake: if ptr was IMEM_WORDS-1 -> FLUSH, else -> LOAD_HI.
  - LD_END: imem[ptr] <= {hi_reg, 8'h00}; LD_COUNT++ -> FLUSH.
- LD_END has priority over a same-cycle byte; that byte is not accepted because LD_READY is low.
- LD_START while in LOAD_HI/LOAD_LO restarts the load: ptr=0, LD_COUNT=0 -> LOAD_HI. Any pending hi byte is discarded.
- LD_START and LD_END in the same cycle: LD_START wins.
- FLUSH: exactly one cycle with CPU_RST=1 -> RUN.
- RUN:
  - CPU_RST=0, RUNNING=1.
  - LD_START -> LOAD_HI, and CPU_RST reasserts that same cycle (combinational from next-state is not required; registered from state is acceptable with one-cycle lag, and the CPU must not fetch in LOAD states).
  - LD_END in RUN or HOLD is ignored.
- CPU_RST and RUNNING are decoded directly from the state register.
- Instruction fetch:
  - Iin = imem[PC[7:1]], combinational; PC[0] is ignored.
  - PC[7:1] ≥ IMEM_WORDS reads 16'h0000.
  - Iin forced to 16'h0000 when state≠RUN.
- Data read: Din = dmem[DataA], combinational, 0-latency. Address ≥ DMEM_BYTES reads 8'h00.
- Data write:
  - dmem[DataA] <= DataB on the rising edge when MW=1 and state=RUN.
  - MW is ignored in all other states.
  - Read-during-write at the same address returns old data in that cycle and new data next cycle.
- Dmem is not cleared by reload or reset.
- LD_COUNT saturates naturally at IMEM_WORDS (never exceeds it).
- Reset mid-load: returns to HOLD immediately. Already-written words are kept; the partial hi byte is discarded.

Test Plan:
- Reset, then LD_START, bytes 12,34,56,78, then LD_END -> imem[0]=1234, imem[1]=5678, LD_COUNT=2. FLUSH is 1 cycle, then RUNNING=1, CPU_RST=0; PC=02 gives Iin=5678.
- Odd byte count: LD_START, bytes AB,CD,EF, then LD_END -> imem[1]=EF00, LD_COUNT=2, then RUN.
- LD_END asserted with LD_VALID in LOAD_HI -> LD_READY=0, byte dropped, LD_COUNT unchanged, next state FLUSH.
- In RUN: MW=1, DataA=0x40, DataB=0x5A -> next cycle Din=5A at DataA=0x40. MW=1 during HOLD/LOAD -> dmem unchanged.
- Full load of IMEM_WORDS words with no LD_END -> auto FLUSH after word 127, LD_COUNT=128, and further LD_VALID is not accepted.
- RESET asserted in LOAD_LO -> next cycle HOLD, CPU_RST=1, LD_READY=0, Iin=0000. A new LD_START then reloads from word 0.

Source files
------------

// File: rtl/prog_data_mem_if.sv
// ============================================================================
// prog_data_mem_if
// CPU fetch/load-store bus plus byte-serial loader bus of prog_data_mem.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface prog_data_mem_if;
  logic [7:0]  PC;
  logic [7:0]  DataA;
  logic [7:0]  DataB;
  logic        MW;
  logic [15:0] Iin;
  logic [7:0]  Din;
  logic        CPU_RST;
  logic        LD_START;
  logic        LD_END;
  logic        LD_VALID;
  logic [7:0]  LD_BYTE;
  logic        LD_READY;
  logic [7:0]  LD_COUNT;
  logic        RUNNING;

  modport master (
    output PC, DataA, DataB, MW, LD_START, LD_END, LD_VALID, LD_BYTE,
    input  Iin, Din, CPU_RST, LD_READY, LD_COUNT, RUNNING
  );

  modport slave (
    input  PC, DataA, DataB, MW, LD_START, LD_END, LD_VALID, LD_BYTE,
    output Iin, Din, CPU_RST, LD_READY, LD_COUNT, RUNNING
  );
endinterface

`default_nettype wire

// File: rtl/prog_data_mem.sv
// ============================================================================
// prog_data_mem
// Instruction/data memory for the 8-bit CPU with a byte-serial program loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module prog_data_mem #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_BYTES = 256
) (
  input  logic            CLK,
  input  logic            RESET,
  prog_data_mem_if.slave  bus
);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_LOAD_HI = 3'd1,
    S_LOAD_LO = 3'd2,
    S_FLUSH   = 3'd3,
    S_RUN     = 3'd4
  } state_e;

  localparam logic [6:0] c_last_ptr = 7'(IMEM_WORDS - 1);

  logic [15:0] imem [IMEM_WORDS];
  logic [7:0]  dmem [DMEM_BYTES];

  state_e      state_q, state_d;
  logic [6:0]  ptr_q, ptr_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        imem_we;
  logic [15:0] imem_wdata;
  logic        ld_ready;
  logic [15:0] iin;
  logic [7:0]  din;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_HOLD;
      ptr_q   <= 7'd0;
      hi_q    <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    imem_we    = 1'b0;
    imem_wdata = {hi_q, bus.LD_BYTE};
    ld_ready   = 1'b0;

    // LD_START restarts from any state and outranks LD_END
    if (bus.LD_START) begin
      state_d = S_LOAD_HI;
      ptr_d   = 7'd0;
      cnt_d   = 8'd0;
      hi_d    = 8'd0;
      if (state_q == S_LOAD_HI || state_q == S_LOAD_LO) begin
        ld_ready = ~bus.LD_END;
      end
    end else begin
      case (state_q)
        S_HOLD: begin
          state_d = S_HOLD;
        end
        S_LOAD_HI: begin
          ld_ready = ~bus.LD_END;
          if (bus.LD_END) begin
            state_d = S_FLUSH;
          end else if (bus.LD_VALID) begin
            hi_d    = bus.LD_BYTE;
            state_d = S_LOAD_LO;
          end
        end
        S_LOAD_LO: begin
          ld_ready = ~bus.LD_END;
          if (bus.LD_END) begin
            // A dangling high byte is committed with a zero low byte
            imem_we    = 1'b1;
            imem_wdata = {hi_q, 8'h00};
            cnt_d      = cnt_q + 8'd1;
            state_d    = S_FLUSH;
          end else if (bus.LD_VALID) begin
            imem_we = 1'b1;
            ptr_d   = ptr_q + 7'd1;
            cnt_d   = cnt_q + 8'd1;
            state_d = (ptr_q == c_last_ptr) ? S_FLUSH : S_LOAD_HI;
          end
        end
        S_FLUSH: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  // Memories keep their contents across reset and reload
  always_ff @(posedge CLK) begin
    if (!RESET && imem_we) begin
      imem[ptr_q] <= imem_wdata;
    end
    if (!RESET && state_q == S_RUN && bus.MW && (32'(bus.DataA) < DMEM_BYTES)) begin
      dmem[bus.DataA] <= bus.DataB;
    end
  end

  always_comb begin
    iin = 16'h0000;
    if (state_q == S_RUN && (32'(bus.PC[7:1]) < IMEM_WORDS)) begin
      iin = imem[bus.PC[7:1]];
    end
  end

  always_comb begin
    din = 8'h00;
    if (32'(bus.DataA) < DMEM_BYTES) begin
      din = dmem[bus.DataA];
    end
  end

  assign bus.Iin      = iin;
  assign bus.Din      = din;
  assign bus.LD_READY = ld_ready;
  assign bus.LD_COUNT = cnt_q;
  assign bus.CPU_RST  = (state_q != S_RUN);
  assign bus.RUNNING  = (state_q == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_prog_data_mem.sv
// ============================================================================
// tb_prog_data_mem
// Self-checking bench for prog_data_mem using a queue of expected results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_prog_data_mem;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  prog_data_mem_if bus ();

  prog_data_mem #(
    .IMEM_WORDS(128),
    .DMEM_BYTES(256)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.slave)
  );

  logic [15:0] exp_q [$];
  logic [15:0] exp;
  int total = 0;
  int bad = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    bus.LD_START = 1'b1;
    tick();
    bus.LD_START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.LD_VALID = 1'b1;
    bus.LD_BYTE  = b;
    #1;
    while (!bus.LD_READY && n < 10) begin
      tick();
      n++;
    end
    if (!bus.LD_READY) begin
      total++; bad++;
      $display("FAIL ld_ready_timeout got=0 exp=1");
    end
    tick();
    bus.LD_VALID = 1'b0;
  endtask

  task automatic check_iin(input string name, input logic [7:0] pc);
    bus.PC = pc;
    #1;
    exp = exp_q.pop_front();
    total++;
    if (bus.Iin !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, bus.Iin, exp);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(); tick();
    exp_q.push_back(16'h0000);
    total++;
    if (bus.CPU_RST !== 1'b1) begin bad++; $display("FAIL rst_cpu_rst got=%b exp=1", bus.CPU_RST); end
    total++;
    if (bus.RUNNING !== 1'b0) begin bad++; $display("FAIL rst_running got=%b exp=0", bus.RUNNING); end
    total++;
    if (bus.LD_READY !== 1'b0) begin bad++; $display("FAIL rst_ld_ready got=%b exp=0", bus.LD_READY); end
    total++;
    if (bus.LD_COUNT !== 8'd0) begin bad++; $display("FAIL rst_count got=%h exp=00", bus.LD_COUNT); end
    check_iin("rst_iin", 8'h00);
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_load_basic();
    pulse_start();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    bus.LD_END = 1'b1;
    #1;
    total++;
    if (bus.LD_READY !== 1'b0) begin bad++; $display("FAIL basic_end_ready got=%b exp=0", bus.LD_READY); end
    tick();
    bus.LD_END = 1'b0;
    total++;
    if (bus.LD_COUNT !== 8'd2) begin bad++; $display("FAIL basic_count got=%h exp=02", bus.LD_COUNT); end
    total++;
    if (bus.CPU_RST !== 1'b1 || bus.RUNNING !== 1'b0) begin
      bad++; $display("FAIL basic_flush got=%b%b exp=10", bus.CPU_RST, bus.RUNNING);
    end
    tick();
    total++;
    if (bus.CPU_RST !== 1'b0 || bus.RUNNING !== 1'b1) begin
      bad++; $display("FAIL basic_run got=%b%b exp=01", bus.CPU_RST, bus.RUNNING);
    end
    exp_q.push_back(16'h5678);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    check_iin("basic_pc02", 8'h02);
    check_iin("basic_pc00", 8'h00);
    check_iin("basic_pc03_odd", 8'h03);
  endtask

  task automatic test_odd_count();
    pulse_start();
    total++;
    if (bus.CPU_RST !== 1'b1) begin bad++; $display("FAIL odd_cpu_rst got=%b exp=1", bus.CPU_RST); end
    exp_q.push_back(16'h0000);
    check_iin("odd_iin_in_load", 8'h00);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    bus.LD_END = 1'b1;
    tick();
    bus.LD_END = 1'b0;
    tick();
    total++;
    if (bus.LD_COUNT !== 8'd2) begin bad++; $display("FAIL odd_count got=%h exp=02", bus.LD_COUNT); end
    total++;
    if (bus.RUNNING !== 1'b1) begin bad++; $display("FAIL odd_running got=%b exp=1", bus.RUNNING); end
    exp_q.push_back(16'hEF00);
    exp_q.push_back(16'hABCD);
    check_iin("odd_w1", 8'h02);
    check_iin("odd_w0", 8'h00);
  endtask

  task automatic test_end_priority();
    pulse_start();
    send_byte(8'h11); send_byte(8'h22);
    bus.LD_END   = 1'b1;
    bus.LD_VALID = 1'b1;
    bus.LD_BYTE  = 8'h99;
    #1;
    total++;
    if (bus.LD_READY !== 1'b0) begin bad++; $display("FAIL prio_ready got=%b exp=0", bus.LD_READY); end
    tick();
    bus.LD_END   = 1'b0;
    bus.LD_VALID = 1'b0;
    total++;
    if (bus.LD_COUNT !== 8'd1) begin bad++; $display("FAIL prio_count got=%h exp=01", bus.LD_COUNT); end
    total++;
    if (bus.CPU_RST !== 1'b1 || bus.RUNNING !== 1'b0) begin
      bad++; $display("FAIL prio_flush got=%b%b exp=10", bus.CPU_RST, bus.RUNNING);
    end
    tick();
    exp_q.push_back(16'h1122);
    exp_q.push_back(16'hEF00);
    check_iin("prio_w0", 8'h00);
    check_iin("prio_w1_kept", 8'h02);
  endtask

  task automatic test_dmem();
    bus.DataA = 8'h40; bus.DataB = 8'h5A; bus.MW = 1'b1;
    tick();
    bus.MW = 1'b0;
    #1;
    exp_q.push_back(16'h005A);
    exp = exp_q.pop_front(); total++;
    if ({8'h00, bus.Din} !== exp) begin bad++; $display("FAIL dmem_write got=%h exp=%h", bus.Din, exp[7:0]); end
    bus.DataB = 8'hA5; bus.MW = 1'b1;
    #1;
    exp_q.push_back(16'h005A);
    exp = exp_q.pop_front(); total++;
    if ({8'h00, bus.Din} !== exp) begin bad++; $display("FAIL dmem_rdw_old got=%h exp=%h", bus.Din, exp[7:0]); end
    tick();
    bus.MW = 1'b0;
    #1;
    exp_q.push_back(16'h00A5);
    exp = exp_q.pop_front(); total++;
    if ({8'h00, bus.Din} !== exp) begin bad++; $display("FAIL dmem_rdw_new got=%h exp=%h", bus.Din, exp[7:0]); end
    pulse_start();
    bus.DataB = 8'hFF; bus.MW = 1'b1;
    tick();
    bus.MW = 1'b0;
    #1;
    exp_q.push_back(16'h00A5);
    exp = exp_q.pop_front(); total++;
    if ({8'h00, bus.Din} !== exp) begin bad++; $display("FAIL dmem_load_mw got=%h exp=%h", bus.Din, exp[7:0]); end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    bus.DataB = 8'hEE; bus.MW = 1'b1;
    tick();
    bus.MW = 1'b0;
    #1;
    exp_q.push_back(16'h00A5);
    exp = exp_q.pop_front(); total++;
    if ({8'h00, bus.Din} !== exp) begin bad++; $display("FAIL dmem_hold_mw got=%h exp=%h", bus.Din, exp[7:0]); end
  endtask

  task automatic test_full_load();
    logic [7:0] w;
    pulse_start();
    for (int i = 0; i < 128; i++) begin
      w = 8'(i);
      send_byte(w);
      send_byte(~w);
    end
    bus.LD_VALID = 1'b1;
    bus.LD_BYTE  = 8'h55;
    #1;
    total++;
    if (bus.LD_READY !== 1'b0) begin bad++; $display("FAIL full_flush_ready got=%b exp=0", bus.LD_READY); end
    total++;
    if (bus.LD_COUNT !== 8'd128) begin bad++; $display("FAIL full_count got=%h exp=80", bus.LD_COUNT); end
    total++;
    if (bus.CPU_RST !== 1'b1) begin bad++; $display("FAIL full_flush_rst got=%b exp=1", bus.CPU_RST); end
    tick();
    total++;
    if (bus.LD_READY !== 1'b0 || bus.RUNNING !== 1'b1) begin
      bad++; $display("FAIL full_run got=%b%b exp=01", bus.LD_READY, bus.RUNNING);
    end
    bus.LD_VALID = 1'b0;
    tick();
    total++;
    if (bus.LD_COUNT !== 8'd128) begin bad++; $display("FAIL full_count_hold got=%h exp=80", bus.LD_COUNT); end
    exp_q.push_back(16'h00FF);
    exp_q.push_back(16'h01FE);
    exp_q.push_back(16'h3FC0);
    exp_q.push_back(16'h7F80);
    check_iin("full_w0", 8'h00);
    check_iin("full_w1", 8'h02);
    check_iin("full_w63", 8'h7E);
    check_iin("full_w127", 8'hFF);
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    total++;
    if (bus.CPU_RST !== 1'b1 || bus.RUNNING !== 1'b0) begin
      bad++; $display("FAIL mid_hold got=%b%b exp=10", bus.CPU_RST, bus.RUNNING);
    end
    total++;
    if (bus.LD_READY !== 1'b0) begin bad++; $display("FAIL mid_ready got=%b exp=0", bus.LD_READY); end
    total++;
    if (bus.LD_COUNT !== 8'd0) begin bad++; $display("FAIL mid_count got=%h exp=00", bus.LD_COUNT); end
    exp_q.push_back(16'h0000);
    check_iin("mid_iin", 8'h00);
    pulse_start();
    send_byte(8'hAA); send_byte(8'hBB);
    bus.LD_END = 1'b1;
    tick();
    bus.LD_END = 1'b0;
    tick();
    total++;
    if (bus.LD_COUNT !== 8'd1) begin bad++; $display("FAIL reload_count got=%h exp=01", bus.LD_COUNT); end
    exp_q.push_back(16'hAABB);
    exp_q.push_back(16'h01FE);
    check_iin("reload_w0", 8'h00);
    check_iin("reload_w1_kept", 8'h02);
  endtask

  initial begin
    bus.PC = 8'h00; bus.DataA = 8'h00; bus.DataB = 8'h00; bus.MW = 1'b0;
    bus.LD_START = 1'b0; bus.LD_END = 1'b0; bus.LD_VALID = 1'b0; bus.LD_BYTE = 8'h00;
    test_reset();
    test_load_basic();
    test_odd_count();
    test_end_priority();
    test_dmem();
    test_full_load();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
